fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: Eka instruction fetch stage. Holds the fetch PC, drives a req/gnt + rvalid memory port and buffers words with their PC in a DEPTH-entry FIFO; redirects flush it.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds a sticky op_misaligned flag that holds fetch after an unaligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ip_redirect,
  input  logic [31:0] ip_redirect_pc,
  output logic        op_imem_req,
  output logic [31:0] op_imem_addr,
  input  logic        ip_imem_gnt,
  input  logic        ip_imem_rvalid,
  input  logic [31:0] ip_imem_rdata,
  output logic        op_valid,
  output logic [31:0] op_inst,
  output logic [31:0] op_pc,
  input  logic        ip_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        op_misaligned
`endif
);

  // Handshakes: a request transfers on a cycle with op_imem_req && ip_imem_gnt; a response
  // transfers on any cycle with ip_imem_rvalid (in request order); an instruction transfers
  // to the decoder on op_valid && ip_ready. Valids never wait on the matching ready.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Back-to-back redirects against a slow memory can stack stale responses beyond DEPTH.
  localparam int unsigned DW = CW + 2;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] drop_cnt;
  logic [CW:0]   in_use;
  logic [31:0]   target;
  logic          hold;
  logic          credit;
  logic          grant;
  logic          push;
  logic          drop;
  logic          pop;

  assign target = {ip_redirect_pc[31:2], 2'b00};
  assign in_use = {1'b0, count} + {1'b0, outstanding};
  assign credit = in_use < (CW + 1)'(DEPTH);

  assign op_imem_req  = !rst && !ip_redirect && !hold && credit;
  assign op_imem_addr = fetch_pc;
  assign grant        = op_imem_req && ip_imem_gnt;

  assign push = !rst && !ip_redirect && ip_imem_rvalid && (drop_cnt == '0);
  assign drop = ip_imem_rvalid && (drop_cnt != '0);

  assign op_valid = !rst && !ip_redirect && (count != '0);
  assign op_inst  = fifo_inst[rd_ptr];
  assign op_pc    = fifo_pc[rd_ptr];
  assign pop      = op_valid && ip_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (ip_redirect) begin
      fetch_pc    <= target;
      resp_pc     <= target;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      // Everything still owed by memory becomes stale; a response landing now is one of them.
      drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(ip_imem_rvalid);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(grant) - CW'(push);
      if (drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= ip_imem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;

  always_ff @(posedge clk) begin
    if (rst) misaligned <= 1'b0;
    else if (ip_redirect) misaligned <= (ip_redirect_pc[1:0] != 2'b00);
  end

  assign hold          = misaligned;
  assign op_misaligned = misaligned;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^ip_redirect_pc[1:0];
  assign hold           = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle table plus randomized traffic against an in-order memory model and a PC-stream scoreboard.
// Build with FETCH_MISALIGN_CHECK_EN to include the misaligned-redirect sequence.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ip_redirect = 1'b0;
  logic [31:0] ip_redirect_pc = '0;
  logic        op_imem_req;
  logic [31:0] op_imem_addr;
  logic        ip_imem_gnt = 1'b0;
  logic        ip_imem_rvalid = 1'b0;
  logic [31:0] ip_imem_rdata = '0;
  logic        op_valid;
  logic [31:0] op_inst;
  logic [31:0] op_pc;
  logic        ip_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        op_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .ip_redirect(ip_redirect),
    .ip_redirect_pc(ip_redirect_pc),
    .op_imem_req(op_imem_req),
    .op_imem_addr(op_imem_addr),
    .ip_imem_gnt(ip_imem_gnt),
    .ip_imem_rvalid(ip_imem_rvalid),
    .ip_imem_rdata(ip_imem_rdata),
    .op_valid(op_valid),
    .op_inst(op_inst),
    .op_pc(op_pc),
    .ip_ready(ip_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .op_misaligned(op_misaligned)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Instruction memory content: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive inputs after the falling edge, let memory answer in order, sample outputs.
  task automatic step(input logic r, input logic redir, input logic [31:0] rpc,
                      input logic g, input logic rdy, input int lat);
    logic  rv;
    mreq_t e;
    @(negedge clk);
    rst            = r;
    ip_redirect    = redir;
    ip_redirect_pc = rpc;
    ip_imem_gnt    = g;
    ip_ready       = rdy;
    rv             = !r && (mq.size() > 0) && (mq[0].due <= cyc);
    ip_imem_rvalid = rv;
    if (rv) ip_imem_rdata = mem_word(mq[0].addr);
    else    ip_imem_rdata = $urandom();
    #1;
    s_req   = op_imem_req;
    s_addr  = op_imem_addr;
    s_valid = op_valid;
    s_pc    = op_pc;
    s_inst  = op_inst;
    if (r) mq.delete();
    else begin
      if (rv) void'(mq.pop_front());
      if (op_imem_req && g) begin
        e.addr = op_imem_addr;
        e.due  = cyc + lat;
        mq.push_back(e);
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tbl[24];

  // Expected in-order PC stream since the last reset/redirect.
  logic [31:0] exp_q[$];

  task automatic restart_stream(input logic [31:0] base);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  initial begin
    int          delivered;
    logic        r;
    logic        redir;
    logic        g;
    logic        rdy;
    logic [31:0] rpc;
    logic [31:0] head;

    // Gnt always 1, 1-cycle memory. Columns: redirect, target, ready | req, addr, valid, pc.
    tbl[0]  = mk(0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
    tbl[1]  = mk(0, 32'h0,   1, 1, 32'h4,   0, 32'h0);
    tbl[2]  = mk(0, 32'h0,   1, 0, 32'h0,   1, 32'h0);
    tbl[3]  = mk(0, 32'h0,   1, 1, 32'h8,   1, 32'h4);
    tbl[4]  = mk(0, 32'h0,   1, 1, 32'hC,   0, 32'h0);
    tbl[5]  = mk(0, 32'h0,   1, 0, 32'h0,   1, 32'h8);
    tbl[6]  = mk(0, 32'h0,   1, 1, 32'h10,  1, 32'hC);
    tbl[7]  = mk(0, 32'h0,   1, 1, 32'h14,  0, 32'h0);
    tbl[8]  = mk(1, 32'h100, 1, 0, 32'h0,   0, 32'h0);
    tbl[9]  = mk(0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    tbl[10] = mk(0, 32'h0,   1, 1, 32'h104, 0, 32'h0);
    tbl[11] = mk(0, 32'h0,   0, 0, 32'h0,   1, 32'h100);
    tbl[12] = mk(0, 32'h0,   0, 0, 32'h0,   1, 32'h100);
    tbl[13] = mk(0, 32'h0,   0, 0, 32'h0,   1, 32'h100);
    tbl[14] = mk(0, 32'h0,   0, 0, 32'h0,   1, 32'h100);
    tbl[15] = mk(0, 32'h0,   1, 0, 32'h0,   1, 32'h100);
    tbl[16] = mk(0, 32'h0,   1, 1, 32'h108, 1, 32'h104);
    tbl[17] = mk(0, 32'h0,   1, 1, 32'h10C, 0, 32'h0);
    tbl[18] = mk(1, 32'h180, 1, 0, 32'h0,   0, 32'h0);
    tbl[19] = mk(1, 32'h200, 1, 0, 32'h0,   0, 32'h0);
    tbl[20] = mk(0, 32'h0,   1, 1, 32'h200, 0, 32'h0);
    tbl[21] = mk(0, 32'h0,   1, 1, 32'h204, 0, 32'h0);
    tbl[22] = mk(0, 32'h0,   1, 0, 32'h0,   1, 32'h200);
    tbl[23] = mk(0, 32'h0,   1, 1, 32'h208, 1, 32'h204);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      chk("reset req", 32'(s_req), 32'h0);
      chk("reset valid", 32'(s_valid), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("reset misaligned", 32'(op_misaligned), 32'h0);
`endif
    end

    // Directed cycle table
    for (int i = 0; i < 24; i++) begin
      step(1'b0, tbl[i].redir, tbl[i].rpc, 1'b1, tbl[i].rdy, 1);
      chk($sformatf("row%0d req", i), 32'(s_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("row%0d addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("row%0d valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d pc", i), s_pc, tbl[i].e_pc);
        chk($sformatf("row%0d inst", i), s_inst, mem_word(tbl[i].e_pc));
      end
    end

    // Randomized traffic: random gnt, ready, 1..3 cycle latency, redirects (incl. near wrap), rare resets.
    step(1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b1, 1);
    restart_stream(32'h0000_1000);
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      r     = ($urandom_range(0, 599) == 0);
      redir = !r && ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 4))
        0:       rpc = 32'h0000_0100;
        1:       rpc = 32'h0000_0200;
        2:       rpc = 32'hFFFF_FFF4;
        3:       rpc = 32'hFFFF_FFFC;
        default: rpc = $urandom();
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      rpc[1:0] = 2'b00;
`endif
      g   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      step(r, redir, rpc, g, rdy, $urandom_range(1, 3));
      if (r) begin
        chk("rand rst req", 32'(s_req), 32'h0);
        chk("rand rst valid", 32'(s_valid), 32'h0);
        restart_stream(RESET_PC);
      end else if (redir) begin
        chk("rand redirect req", 32'(s_req), 32'h0);
        chk("rand redirect valid", 32'(s_valid), 32'h0);
        restart_stream({rpc[31:2], 2'b00});
      end else begin
        if (s_req) chk("rand addr align", 32'(s_addr[1:0]), 32'h0);
        if (s_valid) begin
          head = exp_q[0];
          chk("rand pc", s_pc, head);
          chk("rand inst", s_inst, mem_word(head));
          if (rdy) begin
            void'(exp_q.pop_front());
            exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
            delivered++;
          end
        end
      end
    end
    chk("rand progress", 32'(delivered > 400), 32'h1);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Unaligned redirect holds fetch; an aligned one releases it.
    step(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b1, 1);
    chk("mis redirect req", 32'(s_req), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      chk("mis flag set", 32'(op_misaligned), 32'h1);
      chk("mis req held", 32'(s_req), 32'h0);
      chk("mis valid", 32'(s_valid), 32'h0);
    end
    step(1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("mis flag clear", 32'(op_misaligned), 32'h0);
    chk("mis resume req", 32'(s_req), 32'h1);
    chk("mis resume addr", s_addr, 32'h0000_0104);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("mis first valid", 32'(s_valid), 32'h1);
    chk("mis first pc", s_pc, 32'h0000_0104);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
